// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the 9-bit ALU: fetch, operand load, execute, write-back.
// Optional zero flag output enabled by defining ALU_SEQ_CTRL_ZFLAG_EN.
module alu_seq_ctrl #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [14:0]      imem_instr,
    output logic [8:0]       alu_a,
    output logic [8:0]       alu_b,
    output logic [3:0]       alu_op,
    input  logic [8:0]       alu_out,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    input  logic [1:0]       dbg_sel,
    output logic [8:0]       dbg_data
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
    ,
    output logic             zero
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_MOV  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b1000;
    localparam logic [3:0] OP_SUBI = 4'b1001;
    localparam logic [3:0] OP_MOVI = 4'b1010;
    localparam logic [3:0] OP_NOP  = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    logic [2:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [3:0][8:0]   rf_q, rf_d;
    logic [8:0]        a_q, a_d;
    logic [8:0]        b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        rd_q, rd_d;
    logic [8:0]        res_q, res_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
    logic              zero_q, zero_d;
`endif

    logic [3:0] f_op;
    logic [1:0] f_rd;
    logic [1:0] f_rs;
    logic [8:0] f_imm;
    logic       wb_en;

    assign f_op  = imem_instr[14:11];
    assign f_rd  = imem_instr[10:9];
    assign f_imm = imem_instr[8:0];
    assign f_rs  = imem_instr[1:0];

    // NOP and the undefined 1100-1110 codes retire without writing
    assign wb_en = (op_q != OP_NOP) && (op_q[3:2] != 2'b11);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rf_d    = rf_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rd_d    = rd_q;
        res_d   = res_q;
        ret_d   = ret_q;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    op_d    = f_op;
                    rd_d    = f_rd;
                    a_d     = rf_q[f_rd];
                    b_d     = rf_q[f_rs];
                    case (f_op)
                        OP_NOT: b_d = '0;
                        OP_MOV: begin
                            a_d = rf_q[f_rs];
                            b_d = '0;
                        end
                        OP_ADDI, OP_SUBI, OP_MOVI: b_d = f_imm;
                        default: ;
                    endcase
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d = alu_out;
                if (op_q == OP_HALT) begin
                    state_d = S_HALTED;
                    ret_d   = ret_q + CNT_W'(1);
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (wb_en) begin
                    rf_d[rd_q] = res_q;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
                    zero_d = (res_q == 9'h000);
`endif
                end
                pc_d    = pc_q + PC_W'(1);
                ret_d   = ret_q + CNT_W'(1);
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            rf_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_NOP;
            rd_q    <= '0;
            res_q   <= '0;
            ret_q   <= '0;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rf_q    <= rf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            ret_q   <= ret_d;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                       (state_q == S_WB);
    assign halted    = (state_q == S_HALTED);
    assign retired   = ret_q;
    assign dbg_data  = rf_q[dbg_sel];
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
    assign zero      = zero_q;
`endif

endmodule
